// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one read per accepted request to a fixed-latency
// instruction memory and presents the fetched word (or a misalignment fault) to decode.
module fetch_unit #(
  parameter int unsigned ADDR_WIDTH  = 15,
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  enable,
  input  logic                  abort,
  input  logic [31:0]           pc,
  output logic                  done,
  output logic [31:0]           command,
  output logic                  misalign,
  output logic                  busy,
  output logic                  imem_en,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [31:0]           imem_rdata,
  output logic [31:0]           fetch_count
);

  localparam logic [2:0] WaitLoad = 3'(MEM_LATENCY);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e                state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic                  done_q, done_d;
  logic [31:0]           cmd_q, cmd_d;
  logic                  mis_q, mis_d;
  logic                  busy_q, busy_d;
  logic                  en_q, en_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           count_q, count_d;

  // Address bits beyond the memory size wrap; they are deliberately dropped.
  if (ADDR_WIDTH + 2 < 32) begin : g_unused_pc
    logic unused_pc_hi;
    assign unused_pc_hi = ^pc[31:ADDR_WIDTH+2];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    cmd_d   = cmd_q;
    mis_d   = mis_q;
    en_d    = 1'b0;
    addr_d  = addr_q;
    count_d = count_q;

    case (state_q)
      StIdle: begin
        if (enable && !abort) begin
          if (pc[1:0] == 2'b00) begin
            state_d = StIssue;
            en_d    = 1'b1;
            addr_d  = pc[ADDR_WIDTH+1:2];
          end else begin
            // Faulting fetch never touches memory.
            state_d = StDone;
            done_d  = 1'b1;
            mis_d   = 1'b1;
            cmd_d   = 32'h0;
          end
        end
      end
      StIssue: begin
        if (abort) begin
          state_d = StIdle;
        end else begin
          cnt_d   = WaitLoad;
          state_d = StWait;
        end
      end
      StWait: begin
        if (abort) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 3'd1;
          // Counter hits zero on this edge: read data is valid now.
          if (cnt_q <= 3'd1) begin
            state_d = StDone;
            done_d  = 1'b1;
            cmd_d   = imem_rdata;
            mis_d   = 1'b0;
            count_d = count_q + 32'd1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state_q <= StIdle;
      cnt_q   <= 3'd0;
      done_q  <= 1'b0;
      cmd_q   <= 32'h0;
      mis_q   <= 1'b0;
      busy_q  <= 1'b0;
      en_q    <= 1'b0;
      addr_q  <= '0;
      count_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      cmd_q   <= cmd_d;
      mis_q   <= mis_d;
      busy_q  <= busy_d;
      en_q    <= en_d;
      addr_q  <= addr_d;
      count_q <= count_d;
    end
  end

  assign done        = done_q;
  assign command     = cmd_q;
  assign misalign    = mis_q;
  assign busy        = busy_q;
  assign imem_en     = en_q;
  assign imem_addr   = addr_q;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: fixed-latency memory model plus a scoreboard of expected
// done pulses (cycle, command, misalign, fetch_count).
module tb_fetch_unit;

  localparam int AW = 15;
  localparam int L  = 2;

  logic          clk;
  logic          rstn;
  logic          enable;
  logic          abort;
  logic [31:0]   pc;
  logic          done;
  logic [31:0]   command;
  logic          misalign;
  logic          busy;
  logic          imem_en;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_rdata;
  logic [31:0]   fetch_count;

  fetch_unit #(
    .ADDR_WIDTH (AW),
    .MEM_LATENCY(L)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .enable     (enable),
    .abort      (abort),
    .pc         (pc),
    .done       (done),
    .command    (command),
    .misalign   (misalign),
    .busy       (busy),
    .imem_en    (imem_en),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .fetch_count(fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] memword(input logic [AW-1:0] a);
    if (a == 15'd4) return 32'h2001_0005;
    return {a[7:0], a[14:0], 9'h0} ^ 32'h9E37_79B1;
  endfunction

  // Memory returns data exactly L cycles after the edge sampling imem_en;
  // any other cycle shows a poison value.
  logic [31:0] pd [L];
  logic        pv [L];
  always @(posedge clk) begin
    pv[0] <= imem_en;
    pd[0] <= memword(imem_addr);
    for (int i = 1; i < L; i++) begin
      pv[i] <= pv[i-1];
      pd[i] <= pd[i-1];
    end
  end
  assign imem_rdata = (pv[L-1] === 1'b1) ? pd[L-1] : 32'hDEAD_BEEF;

  typedef struct {
    logic [31:0] cmd;
    logic        mis;
    logic [31:0] cnt;
    int          due;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  logic [31:0] model_cnt = 32'h0;
  logic [31:0] last_cmd  = 32'h0;
  logic        last_mis  = 1'b0;

  always @(negedge clk) begin
    if (rstn === 1'b0 && done === 1'b1) begin
      if (sb_q.size() == 0) begin
        check_val("spurious_done", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check_val("done_cycle", cyc, mon_e.due);
        check_val("command", command, mon_e.cmd);
        check_val("misalign", {31'h0, misalign}, {31'h0, mon_e.mis});
        check_val("fetch_count", fetch_count, mon_e.cnt);
      end
    end
  end

  task automatic check_reset_state();
    check_val("rst_done", {31'h0, done}, 32'h0);
    check_val("rst_command", command, 32'h0);
    check_val("rst_misalign", {31'h0, misalign}, 32'h0);
    check_val("rst_busy", {31'h0, busy}, 32'h0);
    check_val("rst_imem_en", {31'h0, imem_en}, 32'h0);
    check_val("rst_imem_addr", {17'h0, imem_addr}, 32'h0);
    check_val("rst_fetch_count", fetch_count, 32'h0);
  endtask

  // abort_at: -1 none, otherwise cycle offset from c0 in which abort is high.
  // poke: pulse enable again in c2 and c4 with a fresh aligned pc.
  task automatic run_fetch(input logic [31:0] p, input int abort_at, input bit poke);
    int   c0;
    bit   aligned;
    bit   cancelled;
    exp_t e;
    @(negedge clk);
    enable    = 1'b1;
    pc        = p;
    abort     = (abort_at == 0);
    c0        = cyc;
    aligned   = (p[1:0] == 2'b00);
    cancelled = (abort_at == 0) || (aligned && abort_at >= 1 && abort_at <= L + 1);
    if (!cancelled) begin
      if (aligned) begin
        model_cnt = model_cnt + 32'd1;
        e.cmd     = memword(p[AW+1:2]);
        e.mis     = 1'b0;
      end else begin
        e.cmd = 32'h0;
        e.mis = 1'b1;
      end
      e.cnt    = model_cnt;
      e.due    = c0 + (aligned ? L + 2 : 1);
      last_cmd = e.cmd;
      last_mis = e.mis;
      sb_q.push_back(e);
    end
    for (int k = 1; k <= L + 3; k++) begin
      @(negedge clk);
      enable = poke && (k == 2 || k == 4);
      if (poke) pc = {$urandom} & 32'hFFFF_FFFC;
      abort = (k == abort_at);
      if (k == 1) begin
        check_val("busy_c1", {31'h0, busy}, {31'h0, (abort_at != 0)});
        check_val("imem_en_c1", {31'h0, imem_en}, {31'h0, (aligned && abort_at != 0)});
        if (aligned && abort_at != 0) check_val("imem_addr_c1", {17'h0, imem_addr}, {17'h0, p[AW+1:2]});
      end
      if (k == 2 && !aligned) check_val("imem_en_c2", {31'h0, imem_en}, 32'h0);
      if (cancelled && abort_at >= 1 && k == abort_at + 1)
        check_val("busy_after_abort", {31'h0, busy}, 32'h0);
    end
    enable = 1'b0;
    abort  = 1'b0;
    check_val("busy_end", {31'h0, busy}, 32'h0);
    check_val("command_hold", command, last_cmd);
    check_val("misalign_hold", {31'h0, misalign}, {31'h0, last_mis});
  endtask

  initial begin
    logic [31:0] rp;
    int          ab;
    rstn   = 1'b1;
    enable = 1'b0;
    abort  = 1'b0;
    pc     = 32'h0;
    #1;
    check_reset_state();
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b0;

    run_fetch(32'h0000_0010, -1, 1'b0);   // basic aligned fetch, word 4
    run_fetch(32'h0000_0013, -1, 1'b0);   // misaligned
    run_fetch(32'h0000_0010, -1, 1'b1);   // extra enables while busy ignored
    run_fetch(32'h0000_2468, -1, 1'b0);
    run_fetch(32'hFFFF_0010, -1, 1'b0);   // upper pc bits wrap
    run_fetch(32'h0000_0040, 2, 1'b0);    // abort in WAIT
    run_fetch(32'h0000_0044, 1, 1'b0);    // abort in ISSUE
    run_fetch(32'h0000_0048, 0, 1'b0);    // abort beats enable in IDLE
    run_fetch(32'h0000_004C, L + 2, 1'b0); // abort in DONE has no effect

    // Counter wrap from all-ones.
    @(negedge clk);
    force dut.count_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.count_q;
    model_cnt = 32'hFFFF_FFFF;
    run_fetch(32'h0000_0100, -1, 1'b0);

    // Reset asserted mid-WAIT.
    @(negedge clk);
    enable = 1'b1;
    pc     = 32'h0000_0080;
    @(negedge clk);
    enable = 1'b0;
    check_val("rst_pre_imem_en", {31'h0, imem_en}, 32'h1);
    @(negedge clk);
    #2 rstn = 1'b1;
    #1;
    check_reset_state();
    model_cnt = 32'h0;
    last_cmd  = 32'h0;
    last_mis  = 1'b0;
    @(negedge clk);
    rstn = 1'b0;
    run_fetch(32'h0000_0080, -1, 1'b0);   // first enable after release honoured
    repeat (4) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      rp = $urandom;
      if ($urandom_range(0, 2) == 0) begin
        if (rp[1:0] == 2'b00) rp[0] = 1'b1;
        ab = -1;
      end else begin
        rp[1:0] = 2'b00;
        ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, L + 2)) : -1;
      end
      run_fetch(rp, ab, 1'b0);
    end

    repeat (4) @(negedge clk);
    check_val("sb_empty", sb_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
